// File: rtl/sram_mask_bank_if.sv
// Access bundle for sram_mask_bank: init/ready handshake, read port and byte-masked write port.
interface sram_mask_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LEN   = 6
);
  logic                      init_req;
  logic                      ready;
  logic                      ren;
  logic [ADDR_LEN-1:0]       raddr;
  logic                      we;
  logic [ADDR_LEN-1:0]       waddr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wmask;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      rvalid;

  modport master (
    output init_req, ren, raddr, we, waddr, wdata, wmask,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  init_req, ren, raddr, we, waddr, wdata, wmask,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/sram_mask_bank.sv
// Simple dual-port byte-masked SRAM bank with a hardware clearing sweep and per-byte write-first forwarding.
// Optional macro SRAM_OUT_REG_EN adds a second output register stage (read latency 2).
module sram_mask_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_LEN   = 6,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic              clk,
  input logic              reset,
  sram_mask_bank_if.slave  bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_LEN;
  localparam logic [ADDR_LEN:0] LAST = (ADDR_LEN+1)'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_LEN:0]     cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_LEN-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [NB-1:0]         mem_be;

  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rdata_p0;
  logic                  vld_p0;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         mask
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++)
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    return res;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The sweep borrows the write port; user writes only reach the array in READY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    mem_addr  = bus.waddr;
    mem_data  = bus.wdata;
    mem_be    = bus.wmask;
    case (state)
      INIT: begin
        mem_we   = 1'b1;
        mem_addr = cnt[ADDR_LEN-1:0];
        mem_data = INIT_VALUE;
        mem_be   = '1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST) state_nxt = READY;
      end
      READY: begin
        mem_we = bus.we;
        if (bus.init_req) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign bus.ready = (state == READY);

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < NB; i++)
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
  end

  assign rd_fire = (state == READY) && bus.ren;

  always_comb begin
    rd_word = mem[bus.raddr];
    if (bus.we && (bus.waddr == bus.raddr))
      rd_word = merge_bytes(mem[bus.raddr], bus.wdata, bus.wmask);
  end

  // Stage 0: registered read result, held when no read is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_p0 <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) rdata_p0 <= rd_word;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic                  vld_p1;

  // Stage 1: output register, holds its value when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) rdata_p1 <= rdata_p0;
    end
  end

  assign bus.rdata  = rdata_p1;
  assign bus.rvalid = vld_p1;
`else
  assign bus.rdata  = rdata_p0;
  assign bus.rvalid = vld_p0;
`endif
endmodule

// File: tb/tb_sram_mask_bank.sv
// Directed and randomized bench for sram_mask_bank against a word-array reference model.
module tb_sram_mask_bank;
  localparam int DW    = 32;
  localparam int AL    = 6;
  localparam int DEPTH = 64;
  localparam int NB    = 4;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_mask_bank_if #(.DATA_WIDTH(DW), .ADDR_LEN(AL)) bus();

  sram_mask_bank #(.DATA_WIDTH(DW), .ADDR_LEN(AL), .INIT_VALUE(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_ready;
  int          m_left;
  logic [31:0] s1_d, s2_d;
  bit          s1_v, s2_v;
  logic [31:0] rd_tmp;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_left  = DEPTH;
    s1_d = '0; s2_d = '0; s1_v = 1'b0; s2_v = 1'b0;
  endtask

  task automatic model_tick();
    logic [31:0] nd;
    bit          nv;
    if (reset) begin
      model_reset();
      return;
    end
    nd = s1_d;
    nv = 1'b0;
    if (LAT == 2) begin
      if (s1_v) s2_d = s1_d;
      s2_v = s1_v;
    end
    if (!m_ready) begin
      m_mem[DEPTH - m_left] = 32'h0;
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else begin
      if (bus.ren) begin
        nv = 1'b1;
        nd = (bus.we && bus.waddr == bus.raddr) ?
             merge(m_mem[bus.raddr], bus.wdata, bus.wmask) : m_mem[bus.raddr];
      end
      if (bus.we) m_mem[bus.waddr] = merge(m_mem[bus.waddr], bus.wdata, bus.wmask);
      if (bus.init_req) begin
        m_ready = 1'b0;
        m_left  = DEPTH;
      end
    end
    s1_d = nd;
    s1_v = nv;
  endtask

  task automatic check_outputs();
    chk("ready",  {31'b0, bus.ready},  {31'b0, m_ready});
    chk("rvalid", {31'b0, bus.rvalid}, {31'b0, (LAT == 2) ? s2_v : s1_v});
    chk("rdata",  bus.rdata,           (LAT == 2) ? s2_d : s1_d);
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    bus.init_req = 1'b0; bus.ren = 1'b0; bus.we = 1'b0;
    bus.raddr = '0; bus.waddr = '0; bus.wdata = '0; bus.wmask = '0;
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] mask);
    bus.we = 1'b1; bus.waddr = 6'(addr); bus.wdata = data; bus.wmask = mask;
    step();
    bus.we = 1'b0;
  endtask

  task automatic do_read(input int addr, input string tag, input logic [31:0] want);
    bus.ren = 1'b1; bus.raddr = 6'(addr);
    step();
    bus.ren = 1'b0;
    repeat (LAT - 1) step();
    chk({tag, "_v"}, {31'b0, bus.rvalid}, 32'd1);
    chk(tag, bus.rdata, want);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) step();
    chk("rst_ready", {31'b0, bus.ready}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    reset = 1'b0;
    repeat (63) step();
    chk("sweep_63", {31'b0, bus.ready}, 32'd0);
    step();
    chk("sweep_64", {31'b0, bus.ready}, 32'd1);

    do_read(63, "rd_3f", 32'h0);

    do_write(5, 32'hAABBCCDD, 4'b1111);
    do_write(5, 32'h11223344, 4'b0101);
    do_read(5, "partial", 32'hAA22CC44);

    repeat (3) begin
      step();
      chk("hold_data", bus.rdata, 32'hAA22CC44);
      chk("hold_vld", {31'b0, bus.rvalid}, 32'd0);
    end

    do_write(7, 32'hDEADBEEF, 4'b1111);
    bus.ren = 1'b1; bus.raddr = 6'd7;
    bus.we = 1'b1; bus.waddr = 6'd7; bus.wdata = 32'h01020304; bus.wmask = 4'b1000;
    step();
    idle();
    repeat (LAT - 1) step();
    chk("coll", bus.rdata, 32'h01ADBEEF);
    chk("coll_v", {31'b0, bus.rvalid}, 32'd1);
    do_read(7, "coll_after", 32'h01ADBEEF);

    do_write(1, 32'h11111111, 4'b1111);
    do_write(2, 32'h22222222, 4'b1111);
    do_write(3, 32'h33333333, 4'b1111);
    bus.init_req = 1'b1;
    step();
    bus.init_req = 1'b0;
    chk("init_rdy0", {31'b0, bus.ready}, 32'd0);
    bus.we = 1'b1; bus.waddr = 6'd2; bus.wdata = 32'hFFFFFFFF; bus.wmask = 4'b1111;
    repeat (63) step();
    chk("init_63", {31'b0, bus.ready}, 32'd0);
    idle();
    step();
    chk("init_64", {31'b0, bus.ready}, 32'd1);
    do_read(1, "clr1", 32'h0);
    do_read(2, "clr2", 32'h0);
    do_read(3, "clr3", 32'h0);

    do_write(9, 32'h12345678, 4'b1111);
    do_read(9, "pre_rst", 32'h12345678);
    bus.init_req = 1'b1;
    step();
    bus.init_req = 1'b0;
    repeat (20) step();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_rdata", bus.rdata, 32'h0);
    chk("arst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    chk("arst_ready", {31'b0, bus.ready}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (63) step();
    chk("resweep_63", {31'b0, bus.ready}, 32'd0);
    step();
    chk("resweep_64", {31'b0, bus.ready}, 32'd1);
    do_read(9, "rst_clr9", 32'h0);

    repeat (400) begin
      bus.ren      = 1'($urandom_range(0, 1));
      bus.we       = 1'($urandom_range(0, 1));
      bus.waddr    = 6'($urandom_range(0, 63));
      bus.raddr    = ($urandom_range(0, 3) == 0) ? bus.waddr : 6'($urandom_range(0, 63));
      bus.wdata    = $urandom;
      bus.wmask    = 4'($urandom_range(0, 15));
      bus.init_req = ($urandom_range(0, 149) == 0);
      step();
    end
    idle();
    repeat (2) step();
    rd_tmp = m_mem[0];
    if (m_ready) do_read(0, "final_rd0", rd_tmp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_mask_bank.md
Name: sram_mask_bank

Overview:
- Parametrised successor to the single-port write-first sram-like model.
- Simple dual-port: one synchronous read port and one byte-masked write port.
- Read-during-write forwarding merges masked bytes.
- Hardware init sweep clears the array after reset or on request, with a ready indication.
- Used as the data/tag bank primitive for next-generation I/D caches, where the cache writes partial words directly without a read-modify-write in the cache FSM.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_LEN, 6, address width; depth = 2**ADDR_LEN
INIT_VALUE, 0, value written to every word by the init sweep (DATA_WIDTH bits)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
init_req  input  1  pulse in READY: start a new clearing sweep
ready  output  1  1 when the bank accepts accesses (state READY)
ren  input  1  read enable
raddr  input  ADDR_LEN  read address
we  input  1  write enable
waddr  input  ADDR_LEN  write address
wdata  input  DATA_WIDTH  write data
wmask  input  DATA_WIDTH/8  byte write mask, bit i covers wdata[8i+7:8i]
rdata  output  DATA_WIDTH  read data, registered
rvalid  output  1  rdata carries the result of a read accepted last cycle

Behaviour:
- Reset (async assert): state=INIT, sweep counter=0, ready=0, rdata=0, rvalid=0. Array contents are not reset directly; they are cleared by the sweep.
- FSM states: INIT, READY.
- INIT:
  - Each cycle writes INIT_VALUE to address = counter, then counter+1.
  - Counter is ADDR_LEN+1 bits. When it reaches depth-1 and that word is written, next state is READY.
  - Sweep takes exactly 2**ADDR_LEN cycles after reset deassert.
  - ren, we, and init_req are ignored. rvalid=0 and rdata holds its value.
- READY:
  - ready=1.
  - init_req=1: state goes to INIT and counter goes to 0 next cycle. A we/ren in the same cycle as init_req is still performed.
- Write (READY, we=1): byte i of word[waddr] takes wdata byte i iff wmask[i]; other bytes are unchanged. wmask=0 means no change.
- Read (READY, ren=1): rdata is valid one cycle after the request and rvalid=1 in that cycle. When ren=0, rvalid=0 next cycle and rdata holds its previous value (no X, no change).
- Same-cycle collision (ren & we & raddr==waddr):
  - rdata returns the merged word: masked bytes from wdata, unmasked bytes from the old contents.
  - This is write-first per byte.
- Different addresses in the same cycle: independent; read returns old contents.
- Write followed by a read of the same address next cycle returns the written data (array updated at the write edge).
- Reset asserted mid-sweep or mid-access: immediately back to INIT with counter=0. Partially swept contents are overwritten by the new sweep.
- Width rules: wmask width is DATA_WIDTH/8; the address compare is the full ADDR_LEN.

Optional Feature:
SRAM_OUT_REG_EN:
- Defined:
  - Adds one output pipeline register after rdata/rvalid; read latency is 2 cycles.
  - The collision merge is captured in stage 1 and carried through unchanged.
  - The output stage resets to 0 asynchronously.
  - The hold-when-idle rule applies to the final stage.
- Undefined: read latency is 1 cycle, exactly as in Behaviour.

Test Plan:
- Reset then idle, ADDR_LEN=6: ready=0 for 64 cycles after deassert, then 1. A read of addr 0x3F returns 0x00000000 with rvalid one cycle later (two with SRAM_OUT_REG_EN).
- Partial write: write 0xAABBCCDD mask 4'b1111 to addr 5, then 0x11223344 mask 4'b0101 to addr 5, then read addr 5 -> 0xAA22CC44.
- Collision: word[7]=0xDEADBEEF. In one cycle ren raddr=7 together with we waddr=7 wdata=0x01020304 wmask=4'b1000 -> rdata=0x01ADBEEF. The next read of 7 -> 0x01ADBEEF.
- Idle hold: read addr 5 giving 0xAA22CC44, then ren=0 for 3 cycles -> rdata stays 0xAA22CC44 and rvalid=0.
- init_req in READY after filling addr 1..3 with nonzero data -> ready=0 for 64 cycles. we during the sweep is ignored. Afterwards addrs 1..3 read 0x00000000.
- Reset asserted at sweep counter=20 -> ready stays 0 for a full 64 cycles after deassert. rdata/rvalid read 0 immediately on assertion, without waiting for a clock edge.
